// File: rtl/threshold_pkg.sv
// Shared types and constants for the threshold controller / discriminator pair.
package threshold_pkg;

  localparam int N_P = 12;

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    ARMED,
    ABOVE,
    HOLDOFF
  } disc_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/threshold_discriminator_if.sv
// Sample/threshold input bundle and event outputs of the threshold discriminator.
interface threshold_discriminator_if #(
  parameter int N_P       = threshold_pkg::N_P,
  parameter int HOLDOFF_W = 8
);
  logic                  enable;
  logic                  sample_valid;
  logic signed [N_P-1:0] sample;
  logic signed [N_P-1:0] threshold;
  logic [HOLDOFF_W-1:0]  holdoff;
  logic                  trig;
  logic signed [N_P-1:0] peak;
  logic                  peak_valid;
  logic                  busy;
  logic [15:0]           event_count;

  modport master (
    output enable, sample_valid, sample, threshold, holdoff,
    input  trig, peak, peak_valid, busy, event_count
  );

  modport slave (
    input  enable, sample_valid, sample, threshold, holdoff,
    output trig, peak, peak_valid, busy, event_count
  );
endinterface

// File: rtl/threshold_discriminator.sv
// Upward-crossing discriminator with hysteresis, hold-off, peak capture and a
// saturating event counter. All outputs are registered.
module threshold_discriminator #(
  parameter int N_P       = threshold_pkg::N_P,
  parameter int HYST      = 4,
  parameter int HOLDOFF_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  threshold_discriminator_if.slave    bus
);
  import threshold_pkg::*;

  localparam logic signed [N_P:0] HYST_X = (N_P+1)'(HYST);

  disc_state_t           state;
  logic signed [N_P-1:0] thr_l;
  logic signed [N_P-1:0] peak_r;
  logic [HOLDOFF_W-1:0]  ho_cnt;

  logic                  trig;
  logic signed [N_P-1:0] peak;
  logic                  peak_valid;
  logic                  busy;
  logic [15:0]           event_count;

  // One extra bit so thr_l - HYST cannot wrap near the negative rail.
  logic signed [N_P:0]   rel_lim;
  logic signed [N_P:0]   sample_x;
  logic                  release_hit;

  always_comb begin
    rel_lim     = $signed({thr_l[N_P-1], thr_l}) - HYST_X;
    sample_x    = $signed({bus.sample[N_P-1], bus.sample});
    release_hit = bus.sample_valid && (sample_x < rel_lim);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      thr_l       <= '0;
      peak_r      <= '0;
      ho_cnt      <= '0;
      trig        <= 1'b0;
      peak        <= '0;
      peak_valid  <= 1'b0;
      busy        <= 1'b0;
      event_count <= '0;
    end else begin
      trig       <= 1'b0;
      peak_valid <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMING;
          ARMING: begin
            if (bus.sample_valid && (bus.sample < bus.threshold))
              state <= ARMED;
          end
          ARMED: begin
            if (bus.sample_valid && (bus.sample >= bus.threshold)) begin
              thr_l       <= bus.threshold;
              peak_r      <= bus.sample;
              trig        <= 1'b1;
              event_count <= sat_inc16(event_count);
              busy        <= 1'b1;
              state       <= ABOVE;
            end
          end
          ABOVE: begin
            if (release_hit) begin
              peak       <= peak_r;
              peak_valid <= 1'b1;
              if (bus.holdoff != '0) begin
                ho_cnt <= bus.holdoff;
                state  <= HOLDOFF;
              end else begin
                busy  <= 1'b0;
                state <= ARMING;
              end
            end else if (bus.sample_valid && (bus.sample > peak_r)) begin
              peak_r <= bus.sample;
            end
          end
          HOLDOFF: begin
            // ho_cnt holds the remaining HOLDOFF cycles including this one.
            if (ho_cnt <= HOLDOFF_W'(1)) begin
              busy  <= 1'b0;
              state <= ARMING;
            end else begin
              ho_cnt <= ho_cnt - HOLDOFF_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.trig        = trig;
  assign bus.peak        = peak;
  assign bus.peak_valid  = peak_valid;
  assign bus.busy        = busy;
  assign bus.event_count = event_count;

endmodule

// File: tb/tb_threshold_discriminator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the discriminator rules.
module tb_threshold_discriminator;
  localparam int N_P       = 12;
  localparam int HYST      = 4;
  localparam int HOLDOFF_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  threshold_discriminator_if #(.N_P(N_P), .HOLDOFF_W(HOLDOFF_W)) bus ();

  threshold_discriminator #(.N_P(N_P), .HYST(HYST), .HOLDOFF_W(HOLDOFF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: expected outputs plus abstract bookkeeping of the pulse rules.
  int e_trig, e_pv, e_busy, e_peak, e_cnt;
  bit active, seen_low, in_pulse;
  int dead, m_thr_l, m_pk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_trig = 0; e_pv = 0; e_busy = 0; e_peak = 0; e_cnt = 0;
    active = 0; seen_low = 0; in_pulse = 0; dead = 0; m_thr_l = 0; m_pk = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int s, input int thr,
                            input int ho);
    e_trig = 0;
    e_pv   = 0;
    if (!en) begin
      active = 0; in_pulse = 0; seen_low = 0; dead = 0; e_busy = 0;
    end else if (!active) begin
      active = 1; seen_low = 0;
    end else if (dead > 0) begin
      dead--;
      e_busy = (dead > 0);
    end else if (in_pulse) begin
      if (v) begin
        if (s < m_thr_l - HYST) begin
          e_peak = m_pk; e_pv = 1; in_pulse = 0; seen_low = 0;
          dead = ho; e_busy = (ho != 0);
        end else if (s > m_pk) begin
          m_pk = s;
        end
      end
    end else if (v) begin
      if (!seen_low) begin
        if (s < thr) seen_low = 1;
      end else if (s >= thr) begin
        e_trig = 1;
        if (e_cnt < 65535) e_cnt++;
        in_pulse = 1; m_thr_l = thr; m_pk = s; e_busy = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("trig",        int'(bus.trig),        e_trig);
    check_val("peak_valid",  int'(bus.peak_valid),  e_pv);
    check_val("busy",        int'(bus.busy),        e_busy);
    check_val("peak",        int'(bus.peak),        e_peak);
    check_val("event_count", int'(bus.event_count), e_cnt);
  endtask

  task automatic tick(input bit en, input bit v, input int s, input int thr, input int ho);
    bus.enable       = en;
    bus.sample_valid = v;
    bus.sample       = N_P'(s);
    bus.threshold    = N_P'(thr);
    bus.holdoff      = HOLDOFF_W'(ho);
    @(posedge clk);
    model_step(en, v, s, thr, ho);
    #1;
    compare_all();
  endtask

  task automatic samples(input int thr, input int ho, input int vals[$]);
    foreach (vals[i]) tick(1'b1, 1'b1, vals[i], thr, ho);
  endtask

  function automatic int clamp(input int x);
    if (x < -2048) return -2048;
    if (x > 2047)  return 2047;
    return x;
  endfunction

  initial begin
    bus.enable = 0; bus.sample_valid = 0; bus.sample = '0;
    bus.threshold = '0; bus.holdoff = '0;
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;

    // Basic crossing
    tick(1, 0, 0, 100, 0);
    samples(100, 0, '{50, 50, 120, 130, 110, 90});
    check_val("basic_peak",  int'(bus.peak), 130);
    check_val("basic_count", int'(bus.event_count), 1);

    // Hysteresis: 97 and 99 must not release
    samples(100, 0, '{50, 101, 97, 99, 95});
    check_val("hyst_peak",  int'(bus.peak), 101);
    check_val("hyst_count", int'(bus.event_count), 2);

    // Hold-off with a sample arriving during dead time
    samples(100, 5, '{50, 150, 80});
    tick(1, 0, 0, 100, 5);
    tick(1, 1, 150, 100, 5);
    repeat (4) tick(1, 0, 0, 100, 5);
    samples(100, 5, '{50, 150});
    check_val("holdoff_count", int'(bus.event_count), 4);
    samples(100, 0, '{20});

    // Negative threshold
    samples(-200, 0, '{-300, -150, -180, -250});
    // Threshold at the negative rail: arm high, trigger at -2048, no release possible
    samples(0, 0, '{-100});
    samples(-2048, 0, '{-2048, -2048, -2048, 2047, -2048});
    check_val("rail_busy", int'(bus.busy), 1);
    tick(0, 1, -2048, -2048, 0);
    check_val("rail_abort_busy", int'(bus.busy), 0);

    // Enable abort, then re-enable with the sample stuck high
    tick(1, 0, 0, 100, 0);
    samples(100, 0, '{50, 150, 160});
    tick(0, 1, 150, 100, 0);
    samples(100, 0, '{150, 150, 150, 150, 50, 150, 40});

    // Asynchronous reset in the middle of HOLDOFF
    samples(100, 6, '{50, 150, 60});
    tick(1, 0, 0, 100, 6);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("reset_count", int'(bus.event_count), 0);
    @(posedge clk); #1;
    compare_all();
    reset = 1'b1;
    tick(1, 0, 0, 100, 0);
    samples(100, 0, '{150, 50, 150, 70});
    check_val("post_reset_count", int'(bus.event_count), 1);

    // Randomized traffic
    begin
      int thr_tab[5] = '{100, -200, -2048, 2047, 0};
      int thr = 100;
      for (int n = 0; n < 4000; n++) begin
        bit en = ($urandom_range(0, 99) != 0);
        bit v  = ($urandom_range(0, 3) != 0);
        int ho = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
        int s;
        if ($urandom_range(0, 19) == 0) thr = thr_tab[$urandom_range(0, 4)];
        s = clamp(thr + int'($urandom_range(0, 60)) - 30);
        tick(en, v, s, thr, ho);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
